// File: rtl/fx3_sched_pkg.sv
// Shared types and defaults for the FX3 slave-FIFO write scheduler.
// Imported by the arbiter and the scheduler top.
package fx3_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WRITE,
    PEND,
    DONE
  } state_e;

  localparam logic THREAD0 = 1'b0;
  localparam logic THREAD1 = 1'b1;

  localparam int BURST_DEF   = 4096;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/fx3_rr_arb.sv
// Two-way round-robin arbiter, combinational only.
// ptr_i names the source that wins a tie.
module fx3_rr_arb
  import fx3_sched_pkg::*;
(
  input  logic [1:0] elig_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (elig_i == 2'b11): gnt_o = (ptr_i == THREAD1) ? 2'b10 : 2'b01;
      (elig_i == 2'b01): gnt_o = 2'b01;
      (elig_i == 2'b10): gnt_o = 2'b10;
      default:           gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/fx3_write_scheduler.sv
// Burst scheduler of two 32-bit sources onto the FX3 slave-FIFO write port.
// Grants whole DMA buffers round-robin; stalls commit a short packet.
module fx3_write_scheduler
  import fx3_sched_pkg::*;
#(
  parameter int BURST   = BURST_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        PCLK,
  input  logic        RESET_n,
  input  logic        SRC0_Valid,
  input  logic        SRC1_Valid,
  input  logic [31:0] SRC0_Data,
  input  logic [31:0] SRC1_Data,
  output logic        SRC0_Ready,
  output logic        SRC1_Ready,
  input  logic        DMA0_Ready,
  input  logic        DMA1_Ready,
  output logic        SelectDMA,
  output logic [31:0] DQ,
  output logic        WR_n,
  output logic        PKTEND_n,
  output logic        Busy
);

  localparam int WCW = $clog2(BURST + 1);
  localparam int SCW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             ptr_q, ptr_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [31:0]      dq_q;
  logic             wr_n_q;
  logic             pkt_n_q;
  logic [1:0]       elig;
  logic [1:0]       gnt;
  logic             accept;
  logic [31:0]      wdata;

  assign elig = {SRC1_Valid & DMA1_Ready, SRC0_Valid & DMA0_Ready};

  fx3_rr_arb u_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt)
  );

  // Ready depends on registered state only
  assign SRC0_Ready = (state_q == WRITE) && (sel_q == THREAD0);
  assign SRC1_Ready = (state_q == WRITE) && (sel_q == THREAD1);

  assign accept = (SRC0_Valid & SRC0_Ready) | (SRC1_Valid & SRC1_Ready);
  assign wdata  = (sel_q == THREAD1) ? SRC1_Data : SRC0_Data;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          sel_d   = gnt[1] ? THREAD1 : THREAD0;
          state_d = ADDR;
        end
      end
      ADDR: state_d = WRITE;
      WRITE: begin
        if (accept) begin
          wcnt_d = wcnt_q + WCW'(1);
          scnt_d = '0;
          if (wcnt_d == WCW'(BURST)) state_d = DONE;
        end else begin
          scnt_d = scnt_q + SCW'(1);
          if (scnt_d == SCW'(TIMEOUT)) state_d = PEND;
        end
      end
      PEND: state_d = DONE;
      DONE: begin
        ptr_d   = ~sel_q;
        wcnt_d  = '0;
        scnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      sel_q   <= THREAD0;
      ptr_q   <= THREAD0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      dq_q    <= '0;
      wr_n_q  <= 1'b1;
      pkt_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      if (accept) dq_q <= wdata;
      wr_n_q  <= ~accept;
      pkt_n_q <= ~(state_q == PEND);
    end
  end

  assign SelectDMA = sel_q;
  assign DQ        = dq_q;
  assign WR_n      = wr_n_q;
  assign PKTEND_n  = pkt_n_q;
  assign Busy      = (state_q != IDLE);

endmodule
